// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store access unit between the CPU MEM stage and a slow word-wide data
//   memory. Accepts one byte/half/word access per request (RISC-V funct3),
//   builds byte enables and lane-replicated store data, sign/zero-extends load
//   data, stalls the pipeline until the memory acknowledges, and reports
//   misaligned, illegal or timed-out accesses.
//
// Ports
//   clk, rst        clock; synchronous active-low reset
//   cpu_req/we      request strobe (sampled in IDLE) / 1 = store
//   cpu_addr        byte address
//   cpu_wdata       store data (low bits significant for SB/SH)
//   cpu_f3          funct3: LB0 LH1 LW2 LBU4 LHU5 / SB0 SH1 SW2
//   cpu_stall       combinational pipeline hold
//   cpu_done/err    one-cycle completion / error pulses
//   cpu_rdata       extended load result, held until the next successful load
//   mem_req/we      memory request (held until ack) / write enable
//   mem_addr        word address
//   mem_wdata/be    lane-replicated store data / byte enables (all ones on loads)
//   mem_ack/rdata   memory acknowledge / read word
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_f3,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [TO_W-1:0]   r_cnt;
  logic              r_done;
  logic              r_err;
  logic              r_mem_req;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [31:0]       r_rdata;

  logic              w_illegal;
  logic              w_misalign;
  logic              w_bad;
  logic              w_accept;
  logic              w_last;
  logic [3:0]        w_be;
  logic [31:0]       w_wd;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic              w_unused;

  // Upper byte-address bits are outside the memory's word space.
  assign w_unused = &{1'b0, cpu_addr[31:ADDR_W+2]};

  // Request legality: stores allow only 0..2, loads allow 0,1,2,4,5.
  assign w_illegal  = cpu_we ? (cpu_f3 > 3'd2)
                             : ((cpu_f3 == 3'd3) || (cpu_f3[2:1] == 2'b11));
  assign w_misalign = ((cpu_f3[1:0] == 2'b01) && cpu_addr[0]) ||
                      ((cpu_f3[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00));
  assign w_bad      = w_illegal | w_misalign;
  assign w_accept   = (r_state == S_IDLE) && cpu_req && !w_bad;
  assign w_last     = (r_cnt == TO_W'(TIMEOUT - 1));

  // Store lane placement; loads read the whole word.
  always_comb begin : lane_gen
    w_be = 4'b1111;
    w_wd = cpu_wdata;
    if (cpu_we) begin
      case (cpu_f3[1:0])
        2'b00: begin
          w_be = 4'b0001 << cpu_addr[1:0];
          w_wd = {4{cpu_wdata[7:0]}};
        end
        2'b01: begin
          w_be = cpu_addr[1] ? 4'b1100 : 4'b0011;
          w_wd = {2{cpu_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load lane extraction and extension from the latched request.
  always_comb begin : load_ext
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_f3)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd4:    w_load = {24'd0, w_byte};
      3'd5:    w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin : fsm_next
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) w_next = w_bad ? S_ERR : S_ACCESS;
      end
      S_ACCESS: begin
        // An ack on the final count still completes successfully.
        if (mem_ack)     w_next = S_DONE;
        else if (w_last) w_next = S_ERR;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk) begin : fsm_reg
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_mem_req <= 1'b0;
      r_we      <= 1'b0;
      r_f3      <= 3'd0;
      r_lane    <= 2'd0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_be      <= 4'd0;
      r_rdata   <= 32'd0;
    end else begin
      r_state   <= w_next;
      r_done    <= (w_next == S_DONE) || (w_next == S_ERR);
      r_err     <= (w_next == S_ERR);
      r_mem_req <= (w_next == S_ACCESS);
      if (w_accept) begin
        r_we    <= cpu_we;
        r_f3    <= cpu_f3;
        r_lane  <= cpu_addr[1:0];
        r_addr  <= cpu_addr[ADDR_W+1:2];
        r_wdata <= w_wd;
        r_be    <= w_be;
        r_cnt   <= '0;
      end else if ((r_state == S_ACCESS) && !mem_ack) begin
        r_cnt   <= r_cnt + TO_W'(1);
      end
      if ((r_state == S_ACCESS) && mem_ack && !r_we) r_rdata <= w_load;
    end
  end

  assign cpu_stall = ((r_state == S_IDLE) && cpu_req) || (r_state == S_ACCESS);
  assign cpu_done  = r_done;
  assign cpu_err   = r_err;
  assign cpu_rdata = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [2:0]        cpu_f3;
  logic              cpu_stall;
  logic              cpu_done;
  logic              cpu_err;
  logic [31:0]       cpu_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_f3(cpu_f3),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int t_start = 0;
  int t_done = 0;
  int n_req_cyc = 0;
  int n_done = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle.
  logic        e_stall, e_done, e_err, e_req, e_we;
  logic [31:0] e_rdata, e_wd, e_addr;
  logic [3:0]  e_be;
  logic [31:0] m_rdata;

  logic [3:0]  last_be;
  logic [31:0] last_wd;
  logic [31:0] last_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Spec-level reference functions.
  function automatic bit f_bad(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    bit mis;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = ((f3[1:0] == 2'd1) && (a % 2 != 0)) || ((f3[1:0] == 2'd2) && (a % 4 != 0));
    return !legal || mis;
  endfunction

  function automatic logic [3:0] f_be(input bit we, input logic [2:0] f3, input logic [1:0] a);
    if (!we) return 4'hF;
    case (f3[1:0])
      2'd0:    return 4'(4'b0001 << a);
      2'd1:    return a[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] f_wd(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'd1:    return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * int'(a)));
    h = 16'(w >> (16 * int'(a[1])));
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd1:    return 32'($signed(h));
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  // Single per-cycle comparator against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",    32'(cpu_stall), 32'(e_stall));
      check("done",     32'(cpu_done),  32'(e_done));
      check("err",      32'(cpu_err),   32'(e_err));
      check("mem_req",  32'(mem_req),   32'(e_req));
      check("rdata",    cpu_rdata,      e_rdata);
      if (e_req) begin
        check("mem_addr", 32'(mem_addr), e_addr);
        check("mem_we",   32'(mem_we),   32'(e_we));
        check("mem_be",   32'(mem_be),   32'(e_be));
        if (e_we) check("mem_wdata", mem_wdata, e_wd);
      end
      if (cpu_done) begin
        t_done = cyc;
        n_done++;
      end
      if (mem_req) begin
        n_req_cyc++;
        last_be   = mem_be;
        last_wd   = mem_wdata;
        last_addr = 32'(mem_addr);
      end
    end
  end

  task automatic set_idle();
    e_stall = 1'b0; e_done = 1'b0; e_err = 1'b0; e_req = 1'b0;
    e_rdata = m_rdata;
  endtask

  // One transaction; k = ack delay after mem_req rises (-1 = never ack).
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int k, input logic [31:0] rd,
                         input bit hold);
    bit bad;
    bit ok;
    bad = f_bad(we, f3, a);
    ok  = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_f3 = f3; cpu_addr = a; cpu_wdata = d;
    mem_ack = 1'b0; mem_rdata = rd;
    t_start = cyc;
    set_idle();
    e_stall = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (!bad) begin
      for (int c = 0; c < int'(TIMEOUT); c++) begin
        set_idle();
        e_stall = 1'b1; e_req = 1'b1; e_we = we;
        e_addr  = 32'(a[ADDR_W+1:2]);
        e_be    = f_be(we, f3, a[1:0]);
        e_wd    = f_wd(f3, d);
        mem_ack = (c == k);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (c == k) begin
          ok = 1'b1;
          break;
        end
      end
      if (ok && !we) m_rdata = f_load(f3, a[1:0], rd);
    end
    set_idle();
    e_done = 1'b1;
    e_err  = !ok;
    if (hold) cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    set_idle();
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0;
    cpu_wdata = 32'd0; cpu_f3 = 3'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    m_rdata = 32'd0; e_we = 1'b0; e_addr = 32'd0; e_be = 4'd0; e_wd = 32'd0;
    set_idle();
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // SW with ack two cycles after mem_req
    run_txn(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    check("t1_latency", 32'(t_done - t_start), 32'd4);
    check("t1_addr",    last_addr,              32'd2);
    check("t1_be",      32'(last_be),           32'hF);
    check("t1_wdata",   last_wd,                32'hDEADBEEF);

    // LB / LBU at byte lane 3
    run_txn(1'b0, 3'd0, 32'h7, 32'h0, 0, 32'h80FF1234, 1'b0);
    check("t2_lb",  cpu_rdata, 32'hFFFFFF80);
    run_txn(1'b0, 3'd4, 32'h7, 32'h0, 1, 32'h80FF1234, 1'b0);
    check("t2_lbu", cpu_rdata, 32'h00000080);

    // SH upper half, LHU upper half
    run_txn(1'b1, 3'd1, 32'h2, 32'h0000ABCD, 0, 32'h0, 1'b0);
    check("t3_be",    32'(last_be), 32'hC);
    check("t3_wdata", last_wd,      32'hABCDABCD);
    run_txn(1'b0, 3'd5, 32'h2, 32'h0, 0, 32'hABCD0000, 1'b0);
    check("t3_lhu", cpu_rdata, 32'h0000ABCD);

    // Misaligned LW: immediate error, no memory request
    n_req_cyc = 0;
    run_txn(1'b0, 3'd2, 32'h6, 32'h0, 0, 32'h12345678, 1'b0);
    check("t4_latency", 32'(t_done - t_start), 32'd1);
    check("t4_noreq",   32'(n_req_cyc),        32'd0);
    check("t4_rdata",   cpu_rdata,             32'h0000ABCD);

    // Other illegal / misaligned requests and extra lane cases
    run_txn(1'b1, 3'd3, 32'h0, 32'h1, 0, 32'h0, 1'b0);
    run_txn(1'b0, 3'd6, 32'h0, 32'h0, 0, 32'h0, 1'b0);
    run_txn(1'b0, 3'd1, 32'h1, 32'h0, 0, 32'h0, 1'b0);
    run_txn(1'b1, 3'd0, 32'h5, 32'h000000A5, 3, 32'h0, 1'b0);
    check("sb_be",    32'(last_be), 32'h2);
    check("sb_wdata", last_wd,      32'hA5A5A5A5);
    run_txn(1'b0, 3'd1, 32'h0, 32'h0, 0, 32'h00008001, 1'b0);
    check("lh_sign", cpu_rdata, 32'hFFFF8001);

    // Timeout, then ack on the final allowed cycle
    n_req_cyc = 0;
    run_txn(1'b0, 3'd2, 32'h40, 32'h0, -1, 32'h55AA55AA, 1'b0);
    check("t5_reqcyc", 32'(n_req_cyc),        32'd15);
    check("t5_lat",    32'(t_done - t_start), 32'd16);
    check("t5_rdata",  cpu_rdata,             32'hFFFF8001);
    run_txn(1'b0, 3'd2, 32'h40, 32'h0, 14, 32'h55AA55AA, 1'b0);
    check("t5_last_ack", cpu_rdata, 32'h55AA55AA);

    // Reset during the third ACCESS cycle
    n_done = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_f3 = 3'd2; cpu_addr = 32'h10;
    set_idle(); e_stall = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      set_idle();
      e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 32'd4; e_be = 4'hF;
      if (c == 3) rst = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    m_rdata = 32'd0;
    set_idle();
    repeat (2) @(posedge clk); #1;
    check("t6_nodone", 32'(n_done), 32'd0);

    // Back-to-back: request held through DONE is ignored there
    run_txn(1'b1, 3'd2, 32'hC, 32'h01020304, 0, 32'h0, 1'b1);
    run_txn(1'b0, 3'd0, 32'hC, 32'h0, 1, 32'h0000007F, 1'b0);
    check("t6_b2b", cpu_rdata, 32'h0000007F);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
